// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 pooling engine and its configuration block.
package pool_pkg;

    localparam logic POOL_MODE_MAX = 1'b0;
    localparam logic POOL_MODE_AVG = 1'b1;

    // Width of a column index / width field for a given maximum row width.
    function automatic int unsigned cw_of(input int unsigned maxw);
        return (maxw > 1) ? $clog2(maxw) : 1;
    endfunction

endpackage

// File: rtl/pool_lane_op.sv
// Per-lane combinational pooling operator: signed max, or a widened sum when
// average pooling is built in (POOL_AVG_EN). Output is one bit wider than the
// inputs so a sum never overflows; a max result is sign-extended.
module pool_lane_op
    import pool_pkg::*;
#(
    parameter int unsigned IW = 8
) (
    input  logic [IW-1:0] a,
    input  logic [IW-1:0] b,
    input  logic          mode,
    output logic [IW:0]   y
);

    logic signed [IW:0] a_x;
    logic signed [IW:0] b_x;

    assign a_x = $signed({a[IW-1], a});
    assign b_x = $signed({b[IW-1], b});

    // Select the larger operand, or the sum in average mode
    always_comb begin
        y = (a_x > b_x) ? a_x : b_x;
`ifdef POOL_AVG_EN
        if (mode == POOL_MODE_AVG) begin
            y = a_x + b_x;
        end
`endif
    end

`ifndef POOL_AVG_EN
    logic unused_mode;
    assign unused_mode = mode;
`endif

endmodule

// File: rtl/pool2d_stream.sv
// Streaming 2x2 / stride-2 pooling engine with valid/ready on both sides.
// Max pooling always; average pooling only when POOL_AVG_EN is defined.
// cfg_en=0 passes beats straight through with one cycle of latency.
module pool2d_stream
    import pool_pkg::*;
#(
    parameter int unsigned DW   = 8,
    parameter int unsigned DN   = 7,
    parameter int unsigned MAXW = 64,
    localparam int unsigned CW  = cw_of(MAXW)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_en,
    input  logic             cfg_mode,
    input  logic [CW-1:0]    cfg_width,
    input  logic [DN*DW-1:0] m_data,
    input  logic             m_valid,
    output logic             m_ready,
    input  logic             m_last,
    output logic [DN*DW-1:0] s_data,
    output logic             s_valid,
    input  logic             s_ready,
    output logic             s_last,
    output logic             frame_err
);

`ifdef POOL_AVG_EN
    localparam int unsigned LW = DW + 1;  // partial sums need one extra bit
`else
    localparam int unsigned LW = DW;
`endif

    logic             h_ph_q, h_ph_d;
    logic [CW-1:0]    col_q, col_d;
    logic             rs_q, rs_d;
    logic             in_frame_q, in_frame_d;
    logic             err_q, err_d;
    logic             s_valid_q, s_valid_d;
    logic             s_last_q, s_last_d;
    logic [DN*DW-1:0] s_data_q, s_data_d;

    logic             en_q, mode_q;
    logic [CW-1:0]    width_q;
    logic             en_eff, mode_eff, idle;
    logic [CW-1:0]    width_eff, last_col;

    logic [DN*DW-1:0] hreg_q;
    logic [DN*LW-1:0] lbuf [MAXW];
    logic [DN*LW-1:0] lbuf_rd, h_all;
    logic [DN*DW-1:0] res_all;
    logic             accept, closing, lbuf_we;

    // Config is only taken from the pins between frames with the output empty
    assign idle      = !in_frame_q && !s_valid_q;
    assign en_eff    = idle ? cfg_en    : en_q;
    assign mode_eff  = idle ? cfg_mode  : mode_q;
    assign width_eff = idle ? cfg_width : width_q;
    assign last_col  = (width_eff == '0) ? CW'(MAXW - 1) : width_eff - 1'b1;

    assign m_ready = !s_valid_q || s_ready;
    assign accept  = m_valid && m_ready;
    assign closing = h_ph_q && rs_q && (col_q == last_col);
    assign lbuf_rd = lbuf[col_q];

    for (genvar l = 0; l < DN; l++) begin : g_lane
        logic [DW:0] h1;
        logic [LW:0] s2;

        pool_lane_op #(.IW(DW)) u_h_op (
            .a    (hreg_q[l*DW +: DW]),
            .b    (m_data[l*DW +: DW]),
            .mode (mode_eff),
            .y    (h1)
        );

        pool_lane_op #(.IW(LW)) u_v_op (
            .a    (lbuf_rd[l*LW +: LW]),
            .b    (h_all[l*LW +: LW]),
            .mode (mode_eff),
            .y    (s2)
        );

`ifdef POOL_AVG_EN
        localparam logic [DW+1:0] RND = 2;
        logic [DW+1:0] rnd;
        logic          unused_lane;
        assign h_all[l*LW +: LW] = h1;
        assign rnd               = s2 + RND;
        // Round-half-up divide by four; the quotient always fits DW bits
        assign res_all[l*DW +: DW] = (mode_eff == POOL_MODE_AVG) ? rnd[DW+1:2] : s2[DW-1:0];
        assign unused_lane         = ^rnd[1:0];
`else
        logic unused_lane;
        assign h_all[l*LW +: LW]   = h1[DW-1:0];
        assign res_all[l*DW +: DW] = s2[DW-1:0];
        assign unused_lane         = ^{h1[DW], s2[DW]};
`endif
    end

    // Next-state for window counters, output register and frame error
    always_comb begin
        h_ph_d     = h_ph_q;
        col_d      = col_q;
        rs_d       = rs_q;
        in_frame_d = in_frame_q;
        err_d      = err_q;
        s_valid_d  = s_valid_q && !s_ready;
        s_data_d   = s_data_q;
        s_last_d   = s_last_q;
        lbuf_we    = 1'b0;
        if (accept) begin
            err_d = 1'b0;
            if (!en_eff) begin
                s_valid_d = 1'b1;
                s_data_d  = m_data;
                s_last_d  = m_last;
            end else if (m_last && !closing) begin
                // Truncated frame: drop the partial window and restart
                err_d      = 1'b1;
                h_ph_d     = 1'b0;
                col_d      = '0;
                rs_d       = 1'b0;
                in_frame_d = 1'b0;
            end else begin
                h_ph_d     = !h_ph_q;
                in_frame_d = !m_last;
                if (h_ph_q) begin
                    lbuf_we = !rs_q;
                    if (rs_q) begin
                        s_valid_d = 1'b1;
                        s_data_d  = res_all;
                        s_last_d  = m_last;
                    end
                    if (col_q == last_col) begin
                        col_d = '0;
                        rs_d  = !rs_q;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
        end
    end

    // Control and output state, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_ph_q     <= 1'b0;
            col_q      <= '0;
            rs_q       <= 1'b0;
            in_frame_q <= 1'b0;
            err_q      <= 1'b0;
            s_valid_q  <= 1'b0;
            s_data_q   <= '0;
            s_last_q   <= 1'b0;
            en_q       <= 1'b0;
            mode_q     <= 1'b0;
            width_q    <= '0;
        end else begin
            h_ph_q     <= h_ph_d;
            col_q      <= col_d;
            rs_q       <= rs_d;
            in_frame_q <= in_frame_d;
            err_q      <= err_d;
            s_valid_q  <= s_valid_d;
            s_data_q   <= s_data_d;
            s_last_q   <= s_last_d;
            en_q       <= en_eff;
            mode_q     <= mode_eff;
            width_q    <= width_eff;
        end
    end

    // Horizontal pair register and line buffer (data only, no reset)
    always_ff @(posedge clk) begin
        if (accept && en_eff && !h_ph_q) begin
            hreg_q <= m_data;
        end
        if (accept && lbuf_we) begin
            lbuf[col_q] <= h_all;
        end
    end

    assign s_data    = s_data_q;
    assign s_valid   = s_valid_q;
    assign s_last    = s_last_q;
    assign frame_err = err_q;

endmodule
